// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM channel scanner.
package tdm_pkg;

  // Scanner operating state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FIXED = 2'd2
  } tdm_state_e;

  // Width needed to index num_ch channels (never narrower than one bit).
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_next_ch.sv
// Combinational channel search: lowest set mask bit, next set bit above
// the current channel (wrapping to the lowest), and whether any bit is set.
module tdm_next_ch
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_ch,
  output logic [SEL_W-1:0]  first_ch,
  output logic              any_set
);

  logic first_found_s;
  logic next_found_s;

  // Lowest set bit of the mask; kept separate from the next-bit search so
  // the first channel never depends on the cur input.
  always_comb begin
    any_set       = |mask;
    first_ch      = '0;
    first_found_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i] && !first_found_s) begin
        first_ch      = SEL_W'(i);
        first_found_s = 1'b1;
      end else begin
        first_found_s = first_found_s;
      end
    end
  end

  // Next set bit strictly above cur; falls back to the lowest set bit.
  always_comb begin
    next_ch      = first_ch;
    next_found_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i] && (32'(i) > 32'(cur)) && !next_found_s) begin
        next_ch      = SEL_W'(i);
        next_found_s = 1'b1;
      end else begin
        next_found_s = next_found_s;
      end
    end
  end

endmodule

// File: rtl/tdm_channel_scanner.sv
// Time-division channel scanner: walks the unmasked channels, dwelling
// DWELL cycles on each, or parks on one channel in fixed mode. All outputs
// are registered one cycle after the inputs/channel they reflect.
module tdm_channel_scanner
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 1,
  parameter int DWELL  = 1,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode_fixed,
  input  logic [SEL_W-1:0]         fixed_ch,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic [SEL_W-1:0]         sel_out,
  output logic [NUM_CH-1:0]        strobe,
  output logic                     frame_start
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  // Data of channel ch; zero when ch does not name a real channel.
  function automatic logic [DATA_W-1:0] pick_data(
    input logic [NUM_CH*DATA_W-1:0] data,
    input logic [SEL_W-1:0]         ch
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      r = (ch == SEL_W'(i)) ? data[i*DATA_W +: DATA_W] : r;
    end
    return r;
  endfunction

  // One-hot of ch; all zero when ch does not name a real channel.
  function automatic logic [NUM_CH-1:0] one_hot(input logic [SEL_W-1:0] ch);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) begin
      r[i] = (ch == SEL_W'(i));
    end
    return r;
  endfunction

  tdm_state_e        state_q, state_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic [SEL_W-1:0]  sel_out_q, sel_out_d;
  logic [NUM_CH-1:0] strobe_q, strobe_d;
  logic              frame_start_q, frame_start_d;

  logic              entering_s;
  logic [SEL_W-1:0]  eff_ch_s;
  logic [CNT_W-1:0]  eff_cnt_s;
  logic [SEL_W-1:0]  next_ch_s;
  logic [SEL_W-1:0]  first_ch_s;
  logic              any_set_s;

  // A beat issued on the edge that enters SCAN uses the restart point
  // (lowest mask bit, fresh dwell) so no cycle is lost on entry.
  assign entering_s = (state_q != ST_SCAN);
  assign eff_ch_s   = entering_s ? first_ch_s : cur_ch_q;
  assign eff_cnt_s  = entering_s ? '0 : dwell_cnt_q;

  tdm_next_ch #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next_ch (
    .mask     (ch_mask),
    .cur      (eff_ch_s),
    .next_ch  (next_ch_s),
    .first_ch (first_ch_s),
    .any_set  (any_set_s)
  );

  // State the scanner will be in after this edge.
  always_comb begin
    if (!en) begin
      state_d = ST_IDLE;
    end else if (mode_fixed) begin
      state_d = ST_FIXED;
    end else if (any_set_s) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Next channel pointer, dwell count and output beat for that state.
  always_comb begin
    cur_ch_d      = cur_ch_q;
    dwell_cnt_d   = dwell_cnt_q;
    data_out_d    = data_out_q;
    sel_out_d     = sel_out_q;
    data_valid_d  = 1'b0;
    strobe_d      = '0;
    frame_start_d = 1'b0;
    case (state_d)
      ST_SCAN: begin
        data_out_d    = pick_data(ch_data, eff_ch_s);
        sel_out_d     = eff_ch_s;
        strobe_d      = one_hot(eff_ch_s);
        data_valid_d  = 1'b1;
        frame_start_d = (eff_ch_s == first_ch_s) && (eff_cnt_s == '0);
        if (eff_cnt_s == CNT_LAST) begin
          dwell_cnt_d = '0;
          cur_ch_d    = next_ch_s;
        end else begin
          dwell_cnt_d = eff_cnt_s + CNT_W'(1);
          cur_ch_d    = eff_ch_s;
        end
      end
      ST_FIXED: begin
        cur_ch_d     = fixed_ch;
        dwell_cnt_d  = '0;
        sel_out_d    = fixed_ch;
        data_out_d   = pick_data(ch_data, fixed_ch);
        strobe_d     = one_hot(fixed_ch);
        data_valid_d = (32'(fixed_ch) < 32'(NUM_CH));
      end
      ST_IDLE: begin
        dwell_cnt_d = '0;
      end
      default: begin
        dwell_cnt_d = '0;
      end
    endcase
  end

  // State, channel pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_ch_q      <= '0;
      dwell_cnt_q   <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      sel_out_q     <= '0;
      strobe_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      dwell_cnt_q   <= dwell_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      sel_out_q     <= sel_out_d;
      strobe_q      <= strobe_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign sel_out     = sel_out_q;
  assign strobe      = strobe_q;
  assign frame_start = frame_start_q;

endmodule
